// File: rtl/fp_test_pkg.sv
// Shared types and constants for the pipelined FP adder vector checker.
// Vector words are packed {A, B, expected}, MSB first.
package fp_test_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned SP_W   = 32;
   localparam int unsigned A_HI   = 3 * SP_W - 1;
   localparam int unsigned B_HI   = 2 * SP_W - 1;
   localparam int unsigned EXP_HI = SP_W - 1;

   localparam logic [31:0] ONE  = 32'h3F80_0000;
   localparam logic [31:0] TWO  = 32'h4000_0000;
   localparam logic [31:0] ZERO = 32'h0000_0000;
   localparam logic [31:0] INF  = 32'h7F80_0000;

   function automatic int unsigned a_hi(input int unsigned dw);
      return 3 * dw - 1;
   endfunction

   function automatic int unsigned b_hi(input int unsigned dw);
      return 2 * dw - 1;
   endfunction

   function automatic int unsigned exp_hi(input int unsigned dw);
      return dw - 1;
   endfunction

endpackage

// File: rtl/fp_exp_delay.sv
// LATENCY-deep shift register carrying {valid, index, expected} alongside
// the adder pipeline so each expected value emerges with its DUT result.
module fp_exp_delay #(
   parameter int unsigned LATENCY = 2,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              vld_i,
   input  logic [ADDR_W-1:0] idx_i,
   input  logic [DATA_W-1:0] exp_i,
   output logic              vld_o,
   output logic [ADDR_W-1:0] idx_o,
   output logic [DATA_W-1:0] exp_o,
   output logic              pending_o
);

   logic              vld_q [LATENCY];
   logic [ADDR_W-1:0] idx_q [LATENCY];
   logic [DATA_W-1:0] exp_q [LATENCY];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned k = 0; k < LATENCY; k++) begin
            vld_q[k] <= 1'b0;
            idx_q[k] <= '0;
            exp_q[k] <= '0;
         end
      end else begin
         vld_q[0] <= vld_i;
         idx_q[0] <= idx_i;
         exp_q[0] <= exp_i;
         for (int unsigned k = 1; k < LATENCY; k++) begin
            vld_q[k] <= vld_q[k-1];
            idx_q[k] <= idx_q[k-1];
            exp_q[k] <= exp_q[k-1];
         end
      end
   end

   assign vld_o = vld_q[LATENCY-1];
   assign idx_o = idx_q[LATENCY-1];
   assign exp_o = exp_q[LATENCY-1];

   // Live entries that have not yet reached the compare stage.
   always_comb begin
      pending_o = 1'b0;
      for (int unsigned k = 0; k < LATENCY - 1; k++) begin
         pending_o = pending_o | vld_q[k];
      end
   end

endmodule

// File: rtl/fp_vector_checker.sv
// Streams {A, B, expected} vectors into a pipelined FP adder, aligns the
// expected values to the adder latency and records pass/fail details.
module fp_vector_checker
   import fp_test_pkg::*;
#(
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM         = 11,
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned LATENCY     = 2,
   parameter bit          STOP_ON_ERR = 1'b0,
   parameter int unsigned ERR_W       = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic [ADDR_W-1:0]   vec_addr,
   input  logic [3*DATA_W-1:0] vec_data,
   output logic [DATA_W-1:0]   dut_a,
   output logic [DATA_W-1:0]   dut_b,
   output logic                dut_in_valid,
   input  logic [DATA_W-1:0]   dut_out,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ERR_W-1:0]    err_count,
   output logic [ADDR_W-1:0]   first_err_idx,
   output logic [DATA_W-1:0]   first_err_got,
   output logic [DATA_W-1:0]   first_err_exp
);

   localparam int unsigned       AH       = a_hi(DATA_W);
   localparam int unsigned       BH       = b_hi(DATA_W);
   localparam int unsigned       EH       = exp_hi(DATA_W);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_vld_q, rd_vld_d;
   logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, pexp_q, pexp_d;
   logic              pvld_q, pvld_d;
   logic [ADDR_W-1:0] pidx_q, pidx_d;
   logic [ERR_W-1:0]  err_q, err_d;
   logic [ADDR_W-1:0] fidx_q, fidx_d;
   logic [DATA_W-1:0] fgot_q, fgot_d, fexp_q, fexp_d;
   logic              done_q, done_d, pass_q, pass_d;

   logic              dly_vld, dly_pending, mismatch;
   logic [ADDR_W-1:0] dly_idx;
   logic [DATA_W-1:0] dly_exp;

   fp_exp_delay #(
      .LATENCY (LATENCY),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
   ) u_exp_delay (
      .clk       (clk),
      .reset     (reset),
      .vld_i     (pvld_q),
      .idx_i     (pidx_q),
      .exp_i     (pexp_q),
      .vld_o     (dly_vld),
      .idx_o     (dly_idx),
      .exp_o     (dly_exp),
      .pending_o (dly_pending)
   );

   assign mismatch = dly_vld && (dut_out != dly_exp);

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rd_vld_d = 1'b0;
      rd_idx_d = rd_idx_q;
      a_d      = a_q;
      b_d      = b_q;
      pexp_d   = pexp_q;
      pvld_d   = rd_vld_q;
      pidx_d   = pidx_q;
      err_d    = err_q;
      fidx_d   = fidx_q;
      fgot_d   = fgot_q;
      fexp_d   = fexp_q;
      done_d   = done_q;
      pass_d   = pass_q;

      if (rd_vld_q) begin
         a_d    = vec_data[AH -: DATA_W];
         b_d    = vec_data[BH -: DATA_W];
         pexp_d = vec_data[EH -: DATA_W];
         pidx_d = rd_idx_q;
      end

      if (mismatch) begin
         if (err_q != '1) err_d = err_q + 1'b1;
         if (err_q == '0) begin
            fidx_d = dly_idx;
            fgot_d = dut_out;
            fexp_d = dly_exp;
         end
      end

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RUN;
               addr_d  = '0;
               err_d   = '0;
               fidx_d  = '0;
               fgot_d  = '0;
               fexp_d  = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            // A mismatch under STOP_ON_ERR suppresses this cycle's read so
            // at most the vectors already fetched are still presented.
            if (STOP_ON_ERR && mismatch) begin
               state_d = DRAIN;
            end else begin
               rd_vld_d = 1'b1;
               rd_idx_d = addr_q;
               if (addr_q == LAST_IDX) state_d = DRAIN;
               else                    addr_d  = addr_q + 1'b1;
            end
         end
         DRAIN: begin
            if (!rd_vld_q && !pvld_q && !dly_pending) begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         rd_vld_q <= 1'b0;
         rd_idx_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         pexp_q   <= '0;
         pvld_q   <= 1'b0;
         pidx_q   <= '0;
         err_q    <= '0;
         fidx_q   <= '0;
         fgot_q   <= '0;
         fexp_q   <= '0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         rd_vld_q <= rd_vld_d;
         rd_idx_q <= rd_idx_d;
         a_q      <= a_d;
         b_q      <= b_d;
         pexp_q   <= pexp_d;
         pvld_q   <= pvld_d;
         pidx_q   <= pidx_d;
         err_q    <= err_d;
         fidx_q   <= fidx_d;
         fgot_q   <= fgot_d;
         fexp_q   <= fexp_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
      end
   end

   assign vec_addr      = addr_q;
   assign dut_a         = a_q;
   assign dut_b         = b_q;
   assign dut_in_valid  = pvld_q;
   assign busy          = (state_q == RUN) || (state_q == DRAIN);
   assign done          = done_q;
   assign pass          = pass_q;
   assign err_count     = err_q;
   assign first_err_idx = fidx_q;
   assign first_err_got = fgot_q;
   assign first_err_exp = fexp_q;

endmodule

// File: tb/tb_fp_vector_checker.sv
// Directed bench: several checker configurations, each driving a lookup-table
// stand-in adder with selectable extra delay and its own vector memory.
module tb_fp_vector_checker;

   localparam int NI = 6;
   localparam logic [31:0] F_ONE  = 32'h3F80_0000;
   localparam logic [31:0] F_NONE = 32'hBF80_0000;
   localparam logic [31:0] F_TWO  = 32'h4000_0000;
   localparam logic [31:0] F_ZERO = 32'h0000_0000;
   localparam logic [31:0] F_INF  = 32'h7F80_0000;

   function automatic int unsigned cfg_num(input int g);
      case (g)
         1: return 8;
         4: return 1;
         5: return 5;
         default: return 4;
      endcase
   endfunction

   function automatic int unsigned cfg_lat(input int g);
      case (g)
         2: return 1;
         3: return 5;
         default: return 2;
      endcase
   endfunction

   function automatic int unsigned cfg_errw(input int g);
      return (g == 5) ? 2 : 16;
   endfunction

   function automatic bit cfg_stop(input int g);
      return (g == 1);
   endfunction

   function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
      case ({a, b})
         {F_ONE,  F_ONE }: return F_TWO;
         {F_TWO,  F_NONE}: return F_ONE;
         {F_ZERO, F_ZERO}: return F_ZERO;
         {F_INF,  F_ONE }: return F_INF;
         default:          return a ^ b;
      endcase
   endfunction

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        start        [NI];
   logic        extra        [NI];
   logic [7:0]  vec_addr     [NI];
   logic [31:0] dut_a        [NI];
   logic [31:0] dut_b        [NI];
   logic        dut_in_valid [NI];
   logic        busy         [NI];
   logic        done         [NI];
   logic        pass         [NI];
   logic [15:0] err_count    [NI];
   logic [7:0]  fidx         [NI];
   logic [31:0] fgot         [NI];
   logic [31:0] fexp         [NI];
   logic [95:0] mem          [NI][16];

   for (genvar g = 0; g < NI; g++) begin : g_inst
      localparam int unsigned LAT = cfg_lat(g);
      logic [95:0]            vdata;
      logic [31:0]            dout;
      logic [cfg_errw(g)-1:0] ec;
      logic [31:0]            pipe [LAT+1];

      always @(posedge clk) begin
         vdata   <= mem[g][vec_addr[g][3:0]];
         pipe[0] <= add_model(dut_a[g], dut_b[g]);
         for (int unsigned k = 1; k <= LAT; k++) pipe[k] <= pipe[k-1];
      end

      assign dout         = extra[g] ? pipe[LAT] : pipe[LAT-1];
      assign err_count[g] = 16'(ec);

      fp_vector_checker #(
         .DATA_W      (32),
         .NUM         (cfg_num(g)),
         .ADDR_W      (8),
         .LATENCY     (LAT),
         .STOP_ON_ERR (cfg_stop(g)),
         .ERR_W       (cfg_errw(g))
      ) u_dut (
         .clk           (clk),
         .reset         (reset),
         .start         (start[g]),
         .vec_addr      (vec_addr[g]),
         .vec_data      (vdata),
         .dut_a         (dut_a[g]),
         .dut_b         (dut_b[g]),
         .dut_in_valid  (dut_in_valid[g]),
         .dut_out       (dout),
         .busy          (busy[g]),
         .done          (done[g]),
         .pass          (pass[g]),
         .err_count     (ec),
         .first_err_idx (fidx[g]),
         .first_err_got (fgot[g]),
         .first_err_exp (fexp[g])
      );
   end

   int n_pass = 0;
   int n_tot  = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tot++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h, want %h", name, got, want);
   endtask

   task automatic chk_reset(input int g, input string tag);
      chk($sformatf("%s_g%0d_busy", tag, g),  32'(busy[g]), 32'd0);
      chk($sformatf("%s_g%0d_done", tag, g),  32'(done[g]), 32'd0);
      chk($sformatf("%s_g%0d_pass", tag, g),  32'(pass[g]), 32'd0);
      chk($sformatf("%s_g%0d_err", tag, g),   32'(err_count[g]), 32'd0);
      chk($sformatf("%s_g%0d_ivld", tag, g),  32'(dut_in_valid[g]), 32'd0);
      chk($sformatf("%s_g%0d_a", tag, g),     dut_a[g], 32'd0);
      chk($sformatf("%s_g%0d_b", tag, g),     dut_b[g], 32'd0);
      chk($sformatf("%s_g%0d_addr", tag, g),  32'(vec_addr[g]), 32'd0);
      chk($sformatf("%s_g%0d_fidx", tag, g),  32'(fidx[g]), 32'd0);
      chk($sformatf("%s_g%0d_fgot", tag, g),  fgot[g], 32'd0);
      chk($sformatf("%s_g%0d_fexp", tag, g),  fexp[g], 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      repeat (8) @(posedge clk);
   endtask

   // Vector i cycles through the four reference sums; mask bits corrupt expected.
   task automatic load_mem(input int g, input logic [15:0] mask);
      logic [95:0] v;
      for (int i = 0; i < 16; i++) begin
         case (i % 4)
            0:       v = {F_ONE,  F_ONE,  F_TWO};
            1:       v = {F_TWO,  F_NONE, F_ONE};
            2:       v = {F_ZERO, F_ZERO, F_ZERO};
            default: v = {F_INF,  F_ONE,  F_INF};
         endcase
         if (mask[i]) v[31:0] = 32'h0000_0001;
         mem[g][i] = v;
      end
   endtask

   task automatic run(input int g, input bit poke, output int cyc, output int pres,
                      output int bad);
      @(negedge clk);
      start[g] = 1'b1;
      @(posedge clk);
      #1 start[g] = 1'b0;
      cyc  = 0;
      pres = 0;
      bad  = 0;
      if (busy[g] !== 1'b1 || done[g] !== 1'b0) bad++;
      while (done[g] !== 1'b1 && cyc < 60) begin
         if (dut_in_valid[g] === 1'b1) pres++;
         start[g] = poke && (cyc == 2);
         @(posedge clk);
         #1 cyc++;
         if (done[g] !== 1'b1 && busy[g] !== 1'b1) bad++;
      end
      start[g] = 1'b0;
   endtask

   typedef struct {
      int          g;
      bit          rst;
      bit          xdly;
      bit          poke;
      logic [15:0] mask;
      int          cyc;
      int          plo;
      int          phi;
      int          err;
      bit          ok;
      int          idx;
      logic [31:0] got;
      logic [31:0] wexp;
   } rec_t;

   rec_t tbl [10];

   initial begin
      int cyc, pres, bad;
      rec_t t;

      for (int g = 0; g < NI; g++) begin
         start[g] = 1'b0;
         extra[g] = 1'b0;
         load_mem(g, 16'h0);
      end

      //          g rst x  pk mask      cyc lo hi err ok idx got           exp
      tbl[0] = '{0, 1, 0, 1, 16'h0000,  8, 4, 4, 0, 1, 0, 32'h0,        32'h0};
      tbl[1] = '{0, 0, 0, 0, 16'h0004,  8, 4, 4, 1, 0, 2, 32'h0,        32'h1};
      tbl[2] = '{0, 0, 0, 0, 16'h0000,  8, 4, 4, 0, 1, 0, 32'h0,        32'h0};
      tbl[3] = '{2, 0, 0, 0, 16'h0000,  7, 4, 4, 0, 1, 0, 32'h0,        32'h0};
      tbl[4] = '{3, 0, 0, 0, 16'h0000, 11, 4, 4, 0, 1, 0, 32'h0,        32'h0};
      tbl[5] = '{3, 1, 1, 0, 16'h0000, 11, 4, 4, 4, 0, 0, 32'h0,        F_TWO};
      tbl[6] = '{4, 0, 0, 1, 16'h0000,  5, 1, 1, 0, 1, 0, 32'h0,        32'h0};
      tbl[7] = '{4, 0, 0, 0, 16'h0001,  5, 1, 1, 1, 0, 0, F_TWO,        32'h1};
      tbl[8] = '{5, 0, 0, 0, 16'h001F,  9, 5, 5, 3, 0, 0, F_TWO,        32'h1};
      tbl[9] = '{1, 0, 0, 0, 16'h000A,  0, 4, 5, 2, 0, 1, F_ONE,        32'h1};

      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) chk_reset(g, "por");
      reset = 1'b0;
      repeat (8) @(posedge clk);

      for (int r = 0; r < 10; r++) begin
         t = tbl[r];
         if (t.rst) do_reset();
         @(negedge clk);
         load_mem(t.g, t.mask);
         extra[t.g] = t.xdly;
         run(t.g, t.poke, cyc, pres, bad);
         if (t.cyc != 0) chk($sformatf("r%0d_cycles", r), 32'(cyc), 32'(t.cyc));
         chk($sformatf("r%0d_done", r), 32'(done[t.g]), 32'd1);
         chk($sformatf("r%0d_busy_low", r), 32'(busy[t.g]), 32'd0);
         chk($sformatf("r%0d_busy_hold", r), 32'(bad), 32'd0);
         chk($sformatf("r%0d_pass", r), 32'(pass[t.g]), 32'(t.ok));
         chk($sformatf("r%0d_err", r), 32'(err_count[t.g]), 32'(t.err));
         chk($sformatf("r%0d_fidx", r), 32'(fidx[t.g]), 32'(t.idx));
         chk($sformatf("r%0d_fgot", r), fgot[t.g], t.got);
         chk($sformatf("r%0d_fexp", r), fexp[t.g], t.wexp);
         chk($sformatf("r%0d_presented_in_range", r),
             32'(pres >= t.plo && pres <= t.phi), 32'd1);
         repeat (3) @(posedge clk);
      end

      // Reset in the third RUN cycle with a corrupted vector pending.
      do_reset();
      @(negedge clk);
      load_mem(0, 16'h0004);
      extra[0] = 1'b0;
      start[0] = 1'b1;
      @(posedge clk);
      #1 start[0] = 1'b0;
      repeat (2) @(posedge clk);
      #1 chk("mid_busy_before_reset", 32'(busy[0]), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1 chk_reset(0, "mid");
      reset = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      chk("post_reset_err", 32'(err_count[0]), 32'd0);
      chk("post_reset_done", 32'(done[0]), 32'd0);
      chk("post_reset_busy", 32'(busy[0]), 32'd0);
      run(0, 1'b0, cyc, pres, bad);
      chk("rerun_cycles", 32'(cyc), 32'd8);
      chk("rerun_err", 32'(err_count[0]), 32'd1);
      chk("rerun_fidx", 32'(fidx[0]), 32'd2);
      chk("rerun_fgot", fgot[0], 32'h0);
      chk("rerun_fexp", fexp[0], 32'h1);
      chk("rerun_pass", 32'(pass[0]), 32'd0);
      chk("rerun_presented", 32'(pres), 32'd4);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
